// File: rtl/stdp_pkg.sv
// rtl/stdp_pkg.sv - shared widths, window defaults, FSM states and saturating add for the STDP updater
package stdp_pkg;

    localparam int DT_W       = 8;
    localparam int LUT_W      = 24;
    localparam int DT_MIN_DEF = 2;
    localparam int DT_MAX_DEF = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAPT = 2'd2
    } stdp_state_e;

    // One guard bit makes the signed add overflow-free; the clamp then works on the true sum.
    function automatic logic [LUT_W-1:0] sat_add(
        input logic [LUT_W-1:0] a,
        input logic [LUT_W-1:0] b,
        input logic [LUT_W-1:0] hi,
        input logic [LUT_W-1:0] lo
    );
        logic signed [LUT_W:0] s;
        s = $signed({a[LUT_W-1], a}) + $signed({b[LUT_W-1], b});
        if (s > $signed({hi[LUT_W-1], hi})) begin
            return hi;
        end else if (s < $signed({lo[LUT_W-1], lo})) begin
            return lo;
        end
        return s[LUT_W-1:0];
    endfunction

endpackage

// File: rtl/stdp_dt_counter.sv
// rtl/stdp_dt_counter.sv - saturating cycles-since-spike counter with a seen flag
//   i_spike : spike pulse, restarts the count at 1 and sets the seen flag
//   o_cnt   : cycles since the last spike, saturating at all-ones
//   o_seen  : a spike has occurred since reset
module stdp_dt_counter
    import stdp_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_spike,
    output logic [DT_W-1:0] o_cnt,
    output logic            o_seen
);

    localparam logic [DT_W-1:0] LP_ONE = DT_W'(1);
    localparam logic [DT_W-1:0] LP_SAT = '1;

    logic [DT_W-1:0] r_cnt;
    logic            r_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= LP_SAT;
            r_seen <= 1'b0;
        end else if (i_spike) begin
            r_cnt  <= LP_ONE;
            r_seen <= 1'b1;
        end else if (r_cnt != LP_SAT) begin
            r_cnt <= r_cnt + LP_ONE;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_seen = r_seen;

endmodule

// File: rtl/stdp_weight_updater.sv
// rtl/stdp_weight_updater.sv - STDP lookup initiator and saturating synaptic weight accumulator
//   pre_spike/post_spike           : neuron spike pulses
//   weight_load/weight_init        : synchronous weight preload, wins over any update
//   lut_plus_addr/lut_plus_data    : delta-t lookup to the post-after-pre LUT (data 1 cycle later)
//   lut_minus_addr/lut_minus_data  : delta-t lookup to the pre-after-post LUT (data 1 cycle later)
//   weight                         : signed synaptic weight
//   upd_valid                      : pulse the cycle after a LUT result changed the weight
//   busy                           : lookup in flight
module stdp_weight_updater
    import stdp_pkg::*;
#(
    parameter int               DT_MIN = DT_MIN_DEF,
    parameter int               DT_MAX = DT_MAX_DEF,
    parameter logic [LUT_W-1:0] W_MAX  = 24'h7FFFFF,
    parameter logic [LUT_W-1:0] W_MIN  = 24'h800000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pre_spike,
    input  logic             post_spike,
    input  logic             weight_load,
    input  logic [LUT_W-1:0] weight_init,
    output logic [DT_W-1:0]  lut_plus_addr,
    input  logic [LUT_W-1:0] lut_plus_data,
    output logic [DT_W-1:0]  lut_minus_addr,
    input  logic [LUT_W-1:0] lut_minus_data,
    output logic [LUT_W-1:0] weight,
    output logic             upd_valid,
    output logic             busy
);

    localparam logic [DT_W-1:0] LP_DT_MIN = DT_W'(DT_MIN);
    localparam logic [DT_W-1:0] LP_DT_MAX = DT_W'(DT_MAX);

    logic [DT_W-1:0]  w_cnt_pre, w_cnt_post;
    logic             w_pre_seen, w_post_seen;
    logic             w_plus_evt, w_minus_evt;
    logic             w_plus_pend_eff, w_minus_pend_eff;
    logic [DT_W-1:0]  w_plus_delta_eff, w_minus_delta_eff;
    logic             w_start_plus, w_start_minus, w_req, w_capt;
    logic [LUT_W-1:0] w_capt_data;
    stdp_state_e      r_state, w_next;

    logic             r_plus_pend, r_minus_pend, r_sel_plus;
    logic [DT_W-1:0]  r_plus_delta, r_minus_delta;
    logic [DT_W-1:0]  r_plus_addr, r_minus_addr;
    logic [LUT_W-1:0] r_weight;
    logic             r_upd_valid;

    stdp_dt_counter u_cnt_pre (
        .clk(clk), .rst(rst), .i_spike(pre_spike), .o_cnt(w_cnt_pre), .o_seen(w_pre_seen)
    );

    stdp_dt_counter u_cnt_post (
        .clk(clk), .rst(rst), .i_spike(post_spike), .o_cnt(w_cnt_post), .o_seen(w_post_seen)
    );

    // Coincident spikes mean delta-t of zero, so neither direction fires.
    assign w_plus_evt  = post_spike & ~pre_spike & w_pre_seen &
                         (w_cnt_pre >= LP_DT_MIN) & (w_cnt_pre <= LP_DT_MAX);
    assign w_minus_evt = pre_spike & ~post_spike & w_post_seen &
                         (w_cnt_post >= LP_DT_MIN) & (w_cnt_post <= LP_DT_MAX);

    // The event cycle itself counts as pending so an idle FSM starts the request next cycle.
    assign w_plus_pend_eff   = r_plus_pend | w_plus_evt;
    assign w_minus_pend_eff  = r_minus_pend | w_minus_evt;
    assign w_plus_delta_eff  = w_plus_evt ? w_cnt_pre : r_plus_delta;
    assign w_minus_delta_eff = w_minus_evt ? w_cnt_post : r_minus_delta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_start_plus  = 1'b0;
        w_start_minus = 1'b0;
        w_req         = 1'b0;
        w_capt        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_plus_pend_eff) begin
                    w_next       = REQ;
                    w_start_plus = 1'b1;
                end else if (w_minus_pend_eff) begin
                    w_next        = REQ;
                    w_start_minus = 1'b1;
                end
            end
            REQ: begin
                w_next = CAPT;
                w_req  = 1'b1;
            end
            CAPT: begin
                w_next = IDLE;
                w_capt = 1'b1;
            end
            default: w_next = IDLE;
        endcase
    end

    // A fresh event in the REQ cycle keeps its slot armed; it is newer than the one being served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_plus_pend   <= 1'b0;
            r_plus_delta  <= '0;
            r_minus_pend  <= 1'b0;
            r_minus_delta <= '0;
        end else begin
            if (w_plus_evt) begin
                r_plus_pend  <= 1'b1;
                r_plus_delta <= w_cnt_pre;
            end else if (w_req && r_sel_plus) begin
                r_plus_pend <= 1'b0;
            end
            if (w_minus_evt) begin
                r_minus_pend  <= 1'b1;
                r_minus_delta <= w_cnt_post;
            end else if (w_req && !r_sel_plus) begin
                r_minus_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_plus   <= 1'b0;
            r_plus_addr  <= '0;
            r_minus_addr <= '0;
        end else if (w_start_plus) begin
            r_sel_plus   <= 1'b1;
            r_plus_addr  <= w_plus_delta_eff;
            r_minus_addr <= '0;
        end else if (w_start_minus) begin
            r_sel_plus   <= 1'b0;
            r_plus_addr  <= '0;
            r_minus_addr <= w_minus_delta_eff;
        end else if (w_capt) begin
            r_plus_addr  <= '0;
            r_minus_addr <= '0;
        end
    end

    assign w_capt_data = r_sel_plus ? lut_plus_data : lut_minus_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_weight    <= '0;
            r_upd_valid <= 1'b0;
        end else begin
            r_upd_valid <= w_capt & ~weight_load;
            if (weight_load) begin
                r_weight <= weight_init;
            end else if (w_capt) begin
                r_weight <= sat_add(r_weight, w_capt_data, W_MAX, W_MIN);
            end
        end
    end

    assign lut_plus_addr  = r_plus_addr;
    assign lut_minus_addr = r_minus_addr;
    assign weight         = r_weight;
    assign upd_valid      = r_upd_valid;
    assign busy           = (r_state != IDLE);

endmodule
